// File: rtl/stud_delay_line_pkg.sv
// Shared constants and helpers for the stud_delay_line slice.
`include "stud_audio_defs.vh"

package stud_delay_line_pkg;

    localparam int unsigned StudAudioWidth = `STUD_AUDIO_WIDTH;
    localparam int unsigned StudDefaultDepth = 8;

    function automatic int unsigned stud_tap_w(input int unsigned depth);
        return `STUD_CLOG2(depth);
    endfunction

    function automatic int unsigned stud_cnt_w(input int unsigned depth);
        return `STUD_CLOG2(depth + 1);
    endfunction

endpackage

// File: rtl/stud_audio_defs.vh
// Shared audio datapath defines: default sample width and a clog2 helper.
`ifndef STUD_AUDIO_DEFS_VH
`define STUD_AUDIO_DEFS_VH

`define STUD_AUDIO_WIDTH 16
`define STUD_CLOG2(x) ($clog2(x))

`endif

// File: rtl/stud_dl_stage.sv
// One delay-line stage: WIDTH-bit sample register plus its valid flag.
module stud_dl_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr_i) begin
            data_d = '0;
            vld_d  = 1'b0;
        end else if (en_i) begin
            data_d = data_i;
            vld_d  = valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/stud_delay_line.sv
// Enable-gated sample delay line with selectable output tap and fill tracking.
module stud_delay_line
    import stud_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH = StudAudioWidth,
    parameter int unsigned DEPTH = StudDefaultDepth,
    parameter int unsigned TAP_W = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] fill_o,
    output logic             primed_o
);

    localparam int unsigned NumTaps = 2 ** TAP_W;

    if (TAP_W != stud_tap_w(DEPTH)) begin : g_bad_tap_w
        $error("TAP_W must equal clog2(DEPTH)");
    end
    if (CNT_W != stud_cnt_w(DEPTH)) begin : g_bad_cnt_w
        $error("CNT_W must equal clog2(DEPTH+1)");
    end

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] in_data;
        logic             in_vld;
        if (g == 0) begin : g_head
            assign in_data = data_i;
            assign in_vld  = valid_i;
        end else begin : g_link
            assign in_data = stage_data[g-1];
            assign in_vld  = stage_vld[g-1];
        end
        stud_dl_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (en_i),
            .clr_i   (clr_i),
            .data_i  (in_data),
            .valid_i (in_vld),
            .data_o  (stage_data[g]),
            .valid_o (stage_vld[g])
        );
    end

    // Pad the mux out to every encodable tap so out-of-range taps read as zero.
    logic [WIDTH-1:0]   tap_data [NumTaps];
    logic [NumTaps-1:0] tap_vld;

    for (genvar t = 0; t < NumTaps; t++) begin : g_tap
        if (t < DEPTH) begin : g_real
            assign tap_data[t] = stage_data[t];
            assign tap_vld[t]  = stage_vld[t];
        end else begin : g_pad
            assign tap_data[t] = '0;
            assign tap_vld[t]  = 1'b0;
        end
    end

    assign data_o  = tap_data[tap_i];
    assign valid_o = tap_vld[tap_i];

    logic [CNT_W-1:0] fill_d, fill_q;

    always_comb begin
        fill_d = fill_q;
        if (clr_i) begin
            fill_d = '0;
        end else if (en_i) begin
            unique case ({valid_i, stage_vld[DEPTH-1]})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_o   = fill_q;
    assign primed_o = (fill_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_stud_delay_line.sv
// Directed bench for stud_delay_line: one DEPTH=8 and one DEPTH=6 instance.
module tb_stud_delay_line;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [15:0] data;
    logic        valid;
    logic [2:0]  tap8;
    logic [2:0]  tap6;
    logic [15:0] data8, data6;
    logic        valid8, valid6;
    logic [3:0]  fill8;
    logic [2:0]  fill6;
    logic        primed8, primed6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stud_delay_line #(
        .WIDTH (16),
        .DEPTH (8),
        .TAP_W (3),
        .CNT_W (4)
    ) dut8 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .clr_i    (clr),
        .data_i   (data),
        .valid_i  (valid),
        .tap_i    (tap8),
        .data_o   (data8),
        .valid_o  (valid8),
        .fill_o   (fill8),
        .primed_o (primed8)
    );

    stud_delay_line #(
        .WIDTH (16),
        .DEPTH (6),
        .TAP_W (3),
        .CNT_W (3)
    ) dut6 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .clr_i    (clr),
        .data_i   (data),
        .valid_i  (valid),
        .tap_i    (tap6),
        .data_o   (data6),
        .valid_o  (valid6),
        .fill_o   (fill6),
        .primed_o (primed6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [15:0] d, input logic v,
                        input logic [3:0] f, input logic p);
        chk({tag, "_data"}, 32'(data8), 32'(d));
        chk({tag, "_valid"}, 32'(valid8), 32'(v));
        chk({tag, "_fill"}, 32'(fill8), 32'(f));
        chk({tag, "_primed"}, 32'(primed8), 32'(p));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        data  = '0;
        valid = 1'b0;
        tap8  = 3'd0;
        tap6  = 3'd0;
        #3;
        chk8("reset", 16'h0, 1'b0, 4'd0, 1'b0);
        chk("reset_fill6", 32'(fill6), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Latency through tap 3, fill stepping and prime.
        tap8 = 3'd3;
        en   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            data  = 16'(k);
            valid = 1'b1;
            tick();
            if (k >= 4) chk8("latency", 16'(k - 3), 1'b1, 4'(k > 8 ? 8 : k), k >= 8);
            else        chk8("latency", 16'h0, 1'b0, 4'(k), 1'b0);
        end

        // Stall: everything frozen while en is low.
        en   = 1'b0;
        data = 16'hDEAD;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk8("stall", 16'h7, 1'b1, 4'd8, 1'b1);
        end
        en = 1'b1;
        for (int k = 11; k <= 13; k++) begin
            data = 16'(k);
            tick();
            chk8("resume", 16'(k - 3), 1'b1, 4'd8, 1'b1);
        end

        // A bubble enters while a valid sample leaves the full chain.
        data  = 16'h0;
        valid = 1'b0;
        tick();
        chk8("bubble", 16'd11, 1'b1, 4'd7, 1'b0);
        tap8 = 3'd0;
        #1;
        chk8("bubble_tap0", 16'h0, 1'b0, 4'd7, 1'b0);

        // Clear wins over enable and the incoming sample.
        clr   = 1'b1;
        valid = 1'b1;
        data  = 16'hBEEF;
        tick();
        clr   = 1'b0;
        en    = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tap8 = 3'(t);
            #1;
            chk8("clear", 16'h0, 1'b0, 4'd0, 1'b0);
        end

        // Fill and prime from empty, then drop one with a bubble.
        en   = 1'b1;
        tap8 = 3'd7;
        for (int k = 1; k <= 8; k++) begin
            data = 16'(16'h20 + k);
            tick();
            chk("fill_step", 32'(fill8), 32'(k));
            chk("prime_step", 32'(primed8), 32'(k == 8));
        end
        chk("fill_tap7", 32'(data8), 32'h21);
        valid = 1'b0;
        tick();
        chk("unprime_fill", 32'(fill8), 32'd7);
        chk("unprime", 32'(primed8), 32'd0);

        // Asynchronous reset mid-cycle with a loaded chain.
        en   = 1'b0;
        tap8 = 3'd3;
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_rst", 16'h0, 1'b0, 4'd0, 1'b0);
        #4;
        rst_n = 1'b1;
        #1;
        chk8("post_rst", 16'h0, 1'b0, 4'd0, 1'b0);
        chk("post_rst_fill6", 32'(fill6), 32'd0);
        tick();

        // Illegal taps on the six-stage instance with a full chain.
        en    = 1'b1;
        valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            data = 16'(16'h100 + k);
            tick();
        end
        en = 1'b0;
        chk("d6_fill", 32'(fill6), 32'd6);
        chk("d6_primed", 32'(primed6), 32'd1);
        tap6 = 3'd5;
        #1;
        chk("d6_tap5_data", 32'(data6), 32'h101);
        chk("d6_tap5_valid", 32'(valid6), 32'd1);
        for (int t = 6; t < 8; t++) begin
            tap6 = 3'(t);
            #1;
            chk("d6_illegal_data", 32'(data6), 32'h0);
            chk("d6_illegal_valid", 32'(valid6), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
